fetch_sequencer: RTL and testbench

- Instruction-side counterpart of the single-cycle control decoder. It owns the PC, fetches 16-bit instruction words from instruction memory over a req/ack handshake, and presents each word on `ins` to the decoder.
- It consumes the decoder's PC-control outputs (`ldPC`, `Trans1PC`, `Trans2PC`) to choose the next PC.
- It implements jal/ret in hardware using a return-address stack (RAS).

---
 rtl/fetch_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : PC owner and instruction fetcher for the single-cycle decoder.
//            Runs IDLE -> FETCH -> ISSUE -> UPDATE and resolves jal/ret
//            through a circular return-address stack.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] ins,
    output logic        ins_valid,
    input  logic        exec_done,
    input  logic        ldPC,
    input  logic        Trans1PC,
    input  logic        Trans2PC,
    output logic [15:0] pc,
    output logic        ras_err
);

    localparam int              PTR_W   = $clog2(RAS_DEPTH);
    localparam int              SP_W    = PTR_W + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(RAS_DEPTH);
    localparam logic [4:0]      OP_JAL  = 5'b00010;
    localparam logic [4:0]      OP_RET  = 5'b00011;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_ISSUE  = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      pc_q, pc_d;
    logic [15:0]      ins_q, ins_d;
    logic [15:0]      next_pc_q, next_pc_d;
    logic             push_q, push_d;
    logic             pop_q, pop_d;
    logic             ras_err_q, ras_err_d;
    logic [SP_W-1:0]  sp_q, sp_d;
    logic [PTR_W-1:0] head_q, head_d;

    logic [15:0]      ras_q [RAS_DEPTH];
    logic             ras_we;

    logic [15:0]      off_sext;
    logic [15:0]      pc_inc;
    logic [15:0]      pc_br;
    logic [PTR_W-1:0] top_idx;
    logic             is_jal;
    logic             is_ret;

    assign off_sext = {{5{ins_q[10]}}, ins_q[10:0]};
    assign pc_inc   = pc_q + 16'd1;
    assign pc_br    = pc_q + off_sext;
    assign is_jal   = (ins_q[15:11] == OP_JAL);
    assign is_ret   = (ins_q[15:11] == OP_RET);
    // head points at the next free slot; the newest entry sits just below it
    assign top_idx  = head_q - PTR_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ins_q     <= 16'h0000;
            next_pc_q <= RESET_PC;
            push_q    <= 1'b0;
            pop_q     <= 1'b0;
            ras_err_q <= 1'b0;
            sp_q      <= '0;
            head_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ins_q     <= ins_d;
            next_pc_q <= next_pc_d;
            push_q    <= push_d;
            pop_q     <= pop_d;
            ras_err_q <= ras_err_d;
            sp_q      <= sp_d;
            head_q    <= head_d;
        end
    end

    // Stack storage carries no reset; only sp/head define which entries are live
    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_q[head_q] <= pc_inc;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ins_d     = ins_q;
        next_pc_d = next_pc_q;
        push_d    = push_q;
        pop_d     = pop_q;
        ras_err_d = ras_err_q;
        sp_d      = sp_q;
        head_d    = head_q;
        ras_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                if (imem_ack) begin
                    ins_d   = imem_rdata;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (exec_done) begin
                    push_d  = 1'b0;
                    pop_d   = 1'b0;
                    state_d = S_UPDATE;
                    if (is_jal) begin
                        push_d    = 1'b1;
                        next_pc_d = pc_br;
                    end else if (is_ret) begin
                        pop_d     = 1'b1;
                        next_pc_d = (sp_q == '0) ? pc_inc : ras_q[top_idx];
                    end else if (Trans2PC && ldPC) begin
                        next_pc_d = pc_br;
                    end else if (Trans1PC) begin
                        next_pc_d = pc_inc;
                    end else begin
                        // ldPC alone, not-taken conditionals and ALU ops all step by one
                        next_pc_d = pc_inc;
                    end
                end
            end

            S_UPDATE: begin
                pc_d    = next_pc_q;
                state_d = S_FETCH;
                if (push_q) begin
                    ras_we = 1'b1;
                    head_d = head_q + PTR_W'(1);
                    if (sp_q == SP_FULL) begin
                        ras_err_d = 1'b1;
                    end else begin
                        sp_d = sp_q + SP_W'(1);
                    end
                end
                if (pop_q) begin
                    if (sp_q == '0) begin
                        ras_err_d = 1'b1;
                    end else begin
                        head_d = top_idx;
                        sp_d   = sp_q - SP_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign ins       = ins_q;
    assign ins_valid = (state_q == S_ISSUE);
    assign pc        = pc_q;
    assign ras_err   = ras_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Self-checking bench for fetch_sequencer: directed vector table,
//            corner-case sequences and a randomized run against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] ins;
    logic        ins_valid;
    logic        exec_done = 1'b0;
    logic        ldPC = 1'b0;
    logic        Trans1PC = 1'b0;
    logic        Trans2PC = 1'b0;
    logic [15:0] pc;
    logic        ras_err;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_PC  (16'h0000),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .exec_done  (exec_done),
        .ldPC       (ldPC),
        .Trans1PC   (Trans1PC),
        .Trans2PC   (Trans2PC),
        .pc         (pc),
        .ras_err    (ras_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: architectural PC, LIFO of return addresses, sticky error
    logic [15:0] ref_pc;
    logic        ref_err;
    logic [15:0] ref_stk [$];

    typedef struct {
        logic [15:0] word;
        logic        t1;
        logic        t2;
        logic        ld;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        ref_pc  = 16'h0000;
        ref_err = 1'b0;
        ref_stk.delete();
    endtask

    task automatic model_step(input logic [15:0] word, input logic t1, input logic t2, input logic ld);
        logic [15:0] off;
        off = {{5{word[10]}}, word[10:0]};
        if (word[15:11] == 5'b00010) begin
            if (ref_stk.size() == DEPTH) begin
                void'(ref_stk.pop_front());
                ref_err = 1'b1;
            end
            ref_stk.push_back(ref_pc + 16'd1);
            ref_pc = ref_pc + off;
        end else if (word[15:11] == 5'b00011) begin
            if (ref_stk.size() == 0) begin
                ref_err = 1'b1;
                ref_pc  = ref_pc + 16'd1;
            end else begin
                ref_pc = ref_stk.pop_back();
            end
        end else if (t2 && ld) begin
            ref_pc = ref_pc + off;
        end else begin
            ref_pc = ref_pc + 16'd1;
            if (t1) ref_pc = ref_pc;
        end
    endtask

    task automatic sync_to_fetch();
        for (int k = 0; k < 10 && !imem_req; k++) @(negedge clk);
        check("fetch_reached", imem_req, 1);
    endtask

    // Starts at a negedge in FETCH, ends at the negedge of the following FETCH
    task automatic do_instr(input logic [15:0] word, input int ack_wait, input int exec_wait,
                            input logic t1, input logic t2, input logic ld);
        logic [15:0] prev_ins;
        prev_ins = ins;
        check("fetch_req", imem_req, 1);
        check("fetch_addr", imem_addr, ref_pc);
        check("pc_out", pc, ref_pc);
        imem_ack = 1'b0;
        for (int i = 0; i < ack_wait; i++) begin
            @(negedge clk);
            check("stall_req", imem_req, 1);
            check("stall_addr", imem_addr, ref_pc);
            check("stall_ins", ins, prev_ins);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        check("issue_valid", ins_valid, 1);
        check("issue_ins", ins, word);
        check("issue_noreq", imem_req, 0);
        for (int i = 0; i < exec_wait; i++) begin
            imem_ack = 1'b1;
            @(negedge clk);
            check("hold_valid", ins_valid, 1);
            check("hold_ins", ins, word);
        end
        imem_ack  = 1'b0;
        exec_done = 1'b1;
        Trans1PC  = t1;
        Trans2PC  = t2;
        ldPC      = ld;
        @(negedge clk);
        exec_done = 1'b0;
        Trans1PC  = 1'($urandom);
        Trans2PC  = 1'($urandom);
        ldPC      = 1'($urandom);
        check("update_valid", ins_valid, 0);
        model_step(word, t1, t2, ld);
        @(negedge clk);
        check("next_req", imem_req, 1);
        check("next_addr", imem_addr, ref_pc);
        check("ras_err", ras_err, ref_err);
    endtask

    task automatic apply_reset();
        rst       = 1'b0;
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        sync_to_fetch();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] w;
        int          sel;

        vecs = '{
            '{16'h8000, 1'b0, 1'b0, 1'b0, 16'h0001},
            '{16'h8000, 1'b0, 1'b0, 1'b0, 16'h0002},
            '{16'h8000, 1'b0, 1'b0, 1'b0, 16'h0003},
            '{16'h400C, 1'b0, 1'b1, 1'b1, 16'h000F},
            '{16'h8000, 1'b0, 1'b0, 1'b0, 16'h0010},
            '{16'h4005, 1'b0, 1'b1, 1'b1, 16'h0015},
            '{16'h47FB, 1'b0, 1'b1, 1'b1, 16'h0010},
            '{16'h47FE, 1'b0, 1'b1, 1'b1, 16'h000E},
            '{16'h4005, 1'b0, 1'b0, 1'b1, 16'h000F},
            '{16'h4005, 1'b1, 1'b1, 1'b1, 16'h0014},
            '{16'h4005, 1'b1, 1'b0, 1'b0, 16'h0015},
            '{16'h400B, 1'b0, 1'b1, 1'b1, 16'h0020},
            '{16'h1010, 1'b0, 1'b0, 1'b0, 16'h0030},
            '{16'h1800, 1'b0, 1'b0, 1'b0, 16'h0021},
            '{16'h4005, 1'b0, 1'b1, 1'b0, 16'h0022}
        };

        model_reset();
        @(negedge clk);
        check("rst_valid", ins_valid, 0);
        check("rst_req", imem_req, 0);
        check("rst_pc", pc, 16'h0000);
        check("rst_ins", ins, 16'h0000);
        check("rst_err", ras_err, 0);
        rst = 1'b1;
        @(negedge clk);
        sync_to_fetch();

        for (int i = 0; i < 15; i++) begin
            do_instr(vecs[i].word, 0, 0, vecs[i].t1, vecs[i].t2, vecs[i].ld);
            check("vec_addr", imem_addr, vecs[i].exp_addr);
        end

        // Nested calls from 0x22 return in LIFO order
        for (int i = 0; i < 3; i++) do_instr(16'h1010, 0, 0, 1'b0, 1'b0, 1'b0);
        check("nest_addr", imem_addr, 16'h0052);
        for (int i = 0; i < 3; i++) begin
            do_instr(16'h1800, 0, 0, 1'b0, 1'b0, 1'b0);
            check("nest_ret", imem_addr, 16'h0043 - 16'(i * 16));
        end
        check("nest_err", ras_err, 0);

        // Nine pushes of 0x24..0x2C overflow the stack; eight pops get the newest
        for (int i = 0; i < 9; i++) do_instr(16'h1001, 0, 0, 1'b0, 1'b0, 1'b0);
        check("ovf_err", ras_err, 1);
        for (int i = 0; i < 8; i++) begin
            do_instr(16'h1800, 0, 0, 1'b0, 1'b0, 1'b0);
            check("ovf_ret", imem_addr, 16'h002C - 16'(i));
        end
        do_instr(16'h1800, 0, 0, 1'b0, 1'b0, 1'b0);
        check("empty_ret", imem_addr, 16'h0026);

        do_instr(16'h8000, 5, 4, 1'b0, 1'b0, 1'b0);
        check("stall_next", imem_addr, 16'h0027);

        // Reset in the middle of ISSUE, with a stray ack still asserted
        imem_ack   = 1'b1;
        imem_rdata = 16'h8000;
        @(negedge clk);
        check("mid_issue", ins_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", ins_valid, 0);
        check("arst_req", imem_req, 0);
        check("arst_pc", pc, 16'h0000);
        check("arst_ins", ins, 16'h0000);
        check("arst_err", ras_err, 0);
        @(negedge clk);
        imem_ack = 1'b0;
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        sync_to_fetch();
        check("post_rst_addr", imem_addr, 16'h0000);

        do_instr(16'h1800, 0, 0, 1'b0, 1'b0, 1'b0);
        check("underflow_addr", imem_addr, 16'h0001);
        check("underflow_err", ras_err, 1);

        apply_reset();
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            w   = 16'($urandom);
            if (sel < 2) begin
                w[15:11] = 5'b00010;
            end else if (sel < 4) begin
                w[15:11] = 5'b00011;
            end else if (w[15:12] == 4'b0001) begin
                w[15] = 1'b1;
            end
            do_instr(w, $urandom_range(0, 2), $urandom_range(0, 2),
                     1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
